control_unit: RTL and testbench

//  Microsequencer for the CDECV core; drives the datapath's xsrc/xdst/aluop controls from I and SZCy.
//  One instruction = fetch (3 cycles), optional operand fetch (2), then 0-3 execute cycles; one bus transfer per cycle.

---
 rtl/control_unit.sv | 193 +++++++++++++++++++
 tb/tb_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - CDECV microsequencer driving xsrc/xdst/aluop/mem_we from I and SZCy
// Optional CU_SINGLE_STEP_EN adds a step input that gates each instruction start in F0.
module control_unit #(
    parameter logic [4:0] ALUOP_THRU = 5'h00,
    parameter logic [4:0] ALUOP_INC  = 5'h01,
    parameter logic [4:0] ALUOP_BASE = 5'h08
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] I,
    input  logic [2:0] SZCy,
    output logic [2:0] xsrc,
    output logic [9:0] xdst,
    output logic [4:0] aluop,
    output logic       mem_we,
    output logic       halted,
`ifdef CU_SINGLE_STEP_EN
    output logic [3:0] dbg_state,
    input  logic       step
`else
    output logic [3:0] dbg_state
`endif
);

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_O0   = 4'd3,
        S_O1   = 4'd4,
        S_E0   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [2:0] SRC_PC = 3'd0;
    localparam logic [2:0] SRC_A  = 3'd1;
    localparam logic [2:0] SRC_RD = 3'd4;
    localparam logic [2:0] SRC_R  = 3'd5;

    localparam logic [9:0] DST_PC  = 10'h001;
    localparam logic [9:0] DST_A   = 10'h002;
    localparam logic [9:0] DST_MA  = 10'h010;
    localparam logic [9:0] DST_WD  = 10'h020;
    localparam logic [9:0] DST_I   = 10'h040;
    localparam logic [9:0] DST_T   = 10'h080;
    localparam logic [9:0] DST_R   = 10'h100;
    localparam logic [9:0] DST_FLG = 10'h200;

    state_t state, state_nxt;

    logic go;
`ifdef CU_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    // Instruction decode; illegal encodings fall through every class and run as NOP.
    logic op_halt, op_mov, op_alu, op_ld, op_st, op_jmp;
    logic needs_opnd, is_cmp, jmp_taken;
    logic [2:0] src_ss, src_st;
    logic [9:0] dst_dd;

    always_comb begin
        op_halt    = (I == 8'h01);
        op_mov     = (I[7:5] == 3'b001) && !I[4] && (I[3:2] != 2'b00);
        op_alu     = (I[7:5] == 3'b010);
        op_ld      = (I[7:4] == 4'b0110) && (I[3:2] != 2'b00) && (I[1:0] == 2'b00);
        op_st      = (I[7:4] == 4'b0111) && (I[3:2] != 2'b00) && (I[1:0] == 2'b00);
        op_jmp     = (I[7:5] == 3'b100) && (I[1:0] == 2'b00);
        needs_opnd = ((op_mov || op_alu) && (I[1:0] == 2'b00)) || op_ld || op_st || op_jmp;
        is_cmp     = (I[4:2] == 3'b111);
        // Register fields 01/10/11 map directly onto xsrc codes A/B/C.
        src_ss     = (I[1:0] == 2'b00) ? SRC_RD : {1'b0, I[1:0]};
        src_st     = {1'b0, I[3:2]};
        dst_dd     = 10'd1 << I[3:2];
        case (I[4:2])
            3'b001:  jmp_taken = SZCy[1];
            3'b010:  jmp_taken = !SZCy[1];
            3'b011:  jmp_taken = SZCy[0];
            3'b100:  jmp_taken = !SZCy[0];
            3'b101:  jmp_taken = SZCy[2];
            3'b110:  jmp_taken = !SZCy[2];
            default: jmp_taken = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_F0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        xsrc      = SRC_PC;
        xdst      = '0;
        aluop     = ALUOP_THRU;
        mem_we    = 1'b0;
        case (state)
            S_F0: begin
                if (go) begin
                    xdst      = DST_MA | DST_R;
                    aluop     = ALUOP_INC;
                    state_nxt = S_F1;
                end
            end
            S_F1: begin
                xsrc      = SRC_RD;
                xdst      = DST_I;
                state_nxt = S_F2;
            end
            S_F2: begin
                xsrc = SRC_R;
                xdst = DST_PC;
                if (op_halt)                  state_nxt = S_HALT;
                else if (needs_opnd)          state_nxt = S_O0;
                else if (op_mov || op_alu)    state_nxt = S_E0;
                else                          state_nxt = S_F0;
            end
            S_O0: begin
                xdst      = DST_MA | DST_R;
                aluop     = ALUOP_INC;
                state_nxt = S_O1;
            end
            S_O1: begin
                xsrc      = SRC_R;
                xdst      = DST_PC;
                state_nxt = (op_jmp && !jmp_taken) ? S_F0 : S_E0;
            end
            S_E0: begin
                state_nxt = S_F0;
                if (op_mov) begin
                    xsrc = src_ss;
                    xdst = dst_dd;
                end else if (op_alu) begin
                    xsrc      = src_ss;
                    xdst      = DST_T;
                    state_nxt = S_E1;
                end else if (op_ld || op_st) begin
                    xsrc      = SRC_RD;
                    xdst      = DST_MA;
                    state_nxt = S_E1;
                end else if (op_jmp) begin
                    xsrc = SRC_RD;
                    xdst = DST_PC;
                end
            end
            S_E1: begin
                state_nxt = S_F0;
                if (op_alu) begin
                    xsrc      = SRC_A;
                    xdst      = DST_R | DST_FLG;
                    aluop     = ALUOP_BASE + {2'b00, I[4:2]};
                    state_nxt = is_cmp ? S_F0 : S_E2;
                end else if (op_ld) begin
                    xsrc = SRC_RD;
                    xdst = dst_dd;
                end else if (op_st) begin
                    xsrc      = src_st;
                    xdst      = DST_WD;
                    state_nxt = S_E2;
                end
            end
            S_E2: begin
                state_nxt = S_F0;
                if (op_alu) begin
                    xsrc = SRC_R;
                    xdst = DST_A;
                end else if (op_st) begin
                    mem_we = 1'b1;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_F0;
        endcase
        // Reset masks every strobe in the same cycle so an abandoned instruction writes nothing.
        if (reset) begin
            xsrc   = SRC_PC;
            xdst   = '0;
            aluop  = ALUOP_THRU;
            mem_we = 1'b0;
        end
    end

    assign halted    = (state == S_HALT) && !reset;
    assign dbg_state = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench running a small CDECV program on a behavioural datapath
module tb_control_unit;

    logic       clock;
    logic       reset;
    logic [2:0] xsrc;
    logic [9:0] xdst;
    logic [4:0] aluop;
    logic       mem_we;
    logic       halted;
    logic [3:0] dbg_state;
`ifdef CU_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    logic [7:0] pc = 8'h00, a = 8'h00, b = 8'h00, c = 8'h00, t = 8'h00, r = 8'h00;
    logic [7:0] ir = 8'h00, ma = 8'h00, wd = 8'h00;
    logic [2:0] flg = 3'b000;
    logic [7:0] mem [256];
    logic [7:0] rom [256];
    logic [7:0] xbus, rd, alu_res;
    logic [2:0] alu_flg;
    logic [8:0] ext;

    int passed = 0;
    int total = 0;
    int we_cnt = 0;
    int we_bad = 0;

    control_unit dut (
        .clock    (clock),
        .reset    (reset),
        .I        (ir),
        .SZCy     (flg),
        .xsrc     (xsrc),
        .xdst     (xdst),
        .aluop    (aluop),
        .mem_we   (mem_we),
        .halted   (halted),
`ifdef CU_SINGLE_STEP_EN
        .step     (step),
`endif
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        rd = mem[ma];
        case (xsrc)
            3'd0: xbus = pc;
            3'd1: xbus = a;
            3'd2: xbus = b;
            3'd3: xbus = c;
            3'd4: xbus = rd;
            3'd5: xbus = r;
            3'd6: xbus = {5'b0, flg};
            default: xbus = 8'hFF;
        endcase
        ext = {1'b0, xbus};
        case (aluop)
            5'h01: ext = {1'b0, xbus} + 9'd1;
            5'h08: ext = {1'b0, xbus} + {1'b0, t};
            5'h09: ext = {1'b0, xbus} + {1'b0, t} + {8'b0, flg[0]};
            5'h0A: ext = {1'b0, xbus} - {1'b0, t};
            5'h0B: ext = {1'b0, xbus} - {1'b0, t} - {8'b0, flg[0]};
            5'h0C: ext = {1'b0, xbus & t};
            5'h0D: ext = {1'b0, xbus | t};
            5'h0E: ext = {1'b0, xbus ^ t};
            5'h0F: ext = {1'b0, xbus} - {1'b0, t};
            default: ext = {1'b0, xbus};
        endcase
        alu_res = ext[7:0];
        alu_flg = (aluop >= 5'h08) ? {ext[7], ext[7:0] == 8'h00, ext[8]} : flg;
    end

    always @(posedge clock) begin
        if (reset) begin
            pc <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= rom[i];
        end else begin
            if (xdst[0]) pc  <= xbus;
            if (xdst[1]) a   <= xbus;
            if (xdst[2]) b   <= xbus;
            if (xdst[3]) c   <= xbus;
            if (xdst[4]) ma  <= xbus;
            if (xdst[5]) wd  <= xbus;
            if (xdst[6]) ir  <= xbus;
            if (xdst[7]) t   <= xbus;
            if (xdst[8]) r   <= alu_res;
            if (xdst[9]) flg <= alu_flg;
            if (mem_we)  mem[ma] <= wd;
        end
    end

    task automatic run_instr(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            if (mem_we) begin
                we_cnt++;
                if (xdst != 10'h000) we_bad++;
            end
        end while (dbg_state != 4'd0 && cyc < 40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (dbg_state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else passed++;
        total++; if (xdst !== 10'h000 || mem_we !== 1'b0) $display("FAIL reset_strobes: got xdst=%0h we=%0b expected 0/0", xdst, mem_we); else passed++;
        total++; if (xsrc !== 3'd0 || aluop !== 5'h00 || halted !== 1'b0) $display("FAIL reset_idle: got xsrc=%0d aluop=%0h halted=%0b expected 0/0/0", xsrc, aluop, halted); else passed++;
        total++; if (pc !== 8'h00) $display("FAIL reset_pc: got %0h expected 00", pc); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_mov_imm();
        int cyc;
        run_instr(cyc);
        total++; if (cyc != 6) $display("FAIL mov_imm_cycles: got %0d expected 6", cyc); else passed++;
        total++; if (a !== 8'h05 || pc !== 8'h02) $display("FAIL mov_imm_result: got A=%0h PC=%0h expected 05/02", a, pc); else passed++;
    endtask

    task automatic test_alu();
        int cyc;
        run_instr(cyc);
        total++; if (cyc != 8) $display("FAIL add_cycles: got %0d expected 8", cyc); else passed++;
        total++; if (a !== 8'h08 || flg !== 3'b000) $display("FAIL add_result: got A=%0h F=%0b expected 08/000", a, flg); else passed++;
        run_instr(cyc);
        total++; if (cyc != 7) $display("FAIL cmp_cycles: got %0d expected 7", cyc); else passed++;
        total++; if (a !== 8'h08 || flg !== 3'b010) $display("FAIL cmp_result: got A=%0h F=%0b expected 08/010", a, flg); else passed++;
    endtask

    task automatic test_jmp();
        int cyc;
        run_instr(cyc);
        total++; if (cyc != 5 || pc !== 8'h08) $display("FAIL jmp_not_taken: got cyc=%0d PC=%0h expected 5/08", cyc, pc); else passed++;
        run_instr(cyc);
        total++; if (cyc != 6 || pc !== 8'h10) $display("FAIL jmp_taken: got cyc=%0d PC=%0h expected 6/10", cyc, pc); else passed++;
    endtask

    task automatic test_nop_mov_reg();
        int cyc;
        run_instr(cyc);
        total++; if (cyc != 3 || pc !== 8'h11) $display("FAIL nop: got cyc=%0d PC=%0h expected 3/11", cyc, pc); else passed++;
        run_instr(cyc);
        total++; if (cyc != 4 || b !== 8'h08) $display("FAIL mov_reg: got cyc=%0d B=%0h expected 4/08", cyc, b); else passed++;
    endtask

    task automatic test_store_load();
        int cyc;
        we_cnt = 0;
        we_bad = 0;
        run_instr(cyc);
        total++; if (cyc != 8) $display("FAIL st_cycles: got %0d expected 8", cyc); else passed++;
        total++; if (mem[8'h80] !== 8'h08) $display("FAIL st_mem: got %0h expected 08", mem[8'h80]); else passed++;
        total++; if (we_cnt != 1 || we_bad != 0) $display("FAIL st_we: got pulses=%0d overlap=%0d expected 1/0", we_cnt, we_bad); else passed++;
        run_instr(cyc);
        total++; if (cyc != 7 || c !== 8'h08) $display("FAIL ld: got cyc=%0d C=%0h expected 7/08", cyc, c); else passed++;
    endtask

    task automatic test_halt();
        int bad;
        for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
        total++; if (dbg_state !== 4'd8 || halted !== 1'b1) $display("FAIL halt_enter: got state=%0d halted=%0b expected 8/1", dbg_state, halted); else passed++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (xdst != 10'h000 || mem_we || !halted) bad++;
        end
        total++; if (bad != 0) $display("FAIL halt_hold: got %0d active cycles expected 0", bad); else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n;
        do_reset();
        reset = 1'b0;
        run_instr(cyc);
        total++; if (a !== 8'h05) $display("FAIL rerun_mov: got A=%0h expected 05", a); else passed++;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (dbg_state != 4'd6 && n < 20);
        total++; if (dbg_state !== 4'd6) $display("FAIL reach_e1: got state=%0d expected 6", dbg_state); else passed++;
        reset = 1'b1;
        #1;
        total++; if (xdst !== 10'h000) $display("FAIL reset_e1_xdst: got %0h expected 000", xdst); else passed++;
        @(posedge clock); #1;
        total++; if (dbg_state !== 4'd0 || pc !== 8'h00) $display("FAIL reset_e1_state: got state=%0d PC=%0h expected 0/00", dbg_state, pc); else passed++;
        total++; if (a !== 8'h05 || flg !== 3'b010) $display("FAIL reset_e1_regs: got A=%0h F=%0b expected 05/010", a, flg); else passed++;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h24; rom[8'h01] = 8'h05;
        rom[8'h02] = 8'h40; rom[8'h03] = 8'h03;
        rom[8'h04] = 8'h5C; rom[8'h05] = 8'h08;
        rom[8'h06] = 8'h88; rom[8'h07] = 8'h30;
        rom[8'h08] = 8'h84; rom[8'h09] = 8'h10;
        rom[8'h10] = 8'h00;
        rom[8'h11] = 8'h29;
        rom[8'h12] = 8'h78; rom[8'h13] = 8'h80;
        rom[8'h14] = 8'h6C; rom[8'h15] = 8'h80;
        rom[8'h16] = 8'h01;
        test_reset();
        test_mov_imm();
        test_alu();
        test_jmp();
        test_nop_mov_reg();
        test_store_load();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
